// File: rtl/prefix_and_pkg.sv
// prefix_and_pkg: shared constants and the ceil-div helper used to size the per-stage prefix chunk.
package prefix_and_pkg;
  localparam int MAX_N_IN = 32;
  localparam int CNT_W = 16;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/prefix_and_stage.sv
// prefix_and_stage: one pipeline register stage performing cascade AND steps LO..HI-1 (empty range = pass-through).
module prefix_and_stage #(
  parameter int N_IN = 4,
  parameter int LO = 0,
  parameter int HI = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  input  logic [N_IN-2:0] in_prefix,
  output logic            out_valid,
  output logic [N_IN-1:0] out_data,
  output logic [N_IN-2:0] out_prefix
);
  logic            valid_q, valid_d;
  logic [N_IN-1:0] data_q, data_d;
  logic [N_IN-2:0] prefix_q, prefix_d;
  logic [N_IN-1:0] chain;
  // chain[k] is the running product of operand bits 0..k; chain[0] is the seed p[-1] = d[0]
  always_comb begin
    chain = {in_prefix, in_data[0]};
    for (int j = LO; j < HI; j++) chain[j+1] = chain[j] & in_data[j+1];
    valid_d = adv ? in_valid : valid_q;
    data_d = adv ? (in_valid ? in_data : '0) : data_q;
    prefix_d = adv ? (in_valid ? chain[N_IN-1:1] : '0) : prefix_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      prefix_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      prefix_q <= prefix_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_prefix = prefix_q;
endmodule

// File: rtl/prefix_and_pipe.sv
// prefix_and_pipe: pipelined cascade AND prefix with valid/ready handshakes.
// Optional ones_cnt output (saturating count of out_all=1 fires) enabled by PREFIX_AND_CNT_EN.
module prefix_and_pipe import prefix_and_pkg::*; #(
  parameter int N_IN = 4,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N_IN-2:0] out_prefix,
  output logic            out_all,
  output logic            out_valid,
  input  logic            out_ready
`ifdef PREFIX_AND_CNT_EN
  ,
  output logic [CNT_W-1:0] ones_cnt
`endif
);
  localparam int CHUNK = ceil_div(N_IN - 1, STAGES);
  logic                       adv;
  logic [STAGES:0]            v;
  logic [STAGES:0][N_IN-1:0]  d;
  logic [STAGES:0][N_IN-2:0]  p;
  logic                       unused_data;
  // whole pipe advances in lockstep; bubbles are kept, not collapsed
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign p[0] = '0;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * CHUNK;
    localparam int HI = ((s + 1) * CHUNK < N_IN - 1) ? (s + 1) * CHUNK : N_IN - 1;
    prefix_and_stage #(.N_IN(N_IN), .LO(LO), .HI(HI)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .in_valid  (v[s]),
      .in_data   (d[s]),
      .in_prefix (p[s]),
      .out_valid (v[s+1]),
      .out_data  (d[s+1]),
      .out_prefix(p[s+1])
    );
  end
  assign unused_data = ^d[STAGES];
  assign out_valid = v[STAGES];
  assign out_prefix = p[STAGES];
  assign out_all = p[STAGES][N_IN-2];
`ifdef PREFIX_AND_CNT_EN
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  always_comb ones_cnt_d = (out_valid & out_ready & out_all & ~&ones_cnt_q) ? ones_cnt_q + 1'b1 : ones_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) ones_cnt_q <= '0;
    else ones_cnt_q <= ones_cnt_d;
  end
  assign ones_cnt = ones_cnt_q;
`endif
endmodule
